// File: rtl/sdram_arbiter_if.sv
// Request/command bundle between requesters, the arbiter and the SDRAM controller.
// The slave side is the arbiter; the master side is the surrounding environment.
interface sdram_arbiter_if #(
    parameter int N  = 3,
    parameter int AW = 24,
    parameter int DW = 16
);
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_ack, mem_rvalid, mem_rdata,
        output ack, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_ack, mem_rvalid, mem_rdata,
        input  ack, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter funnelling N requesters into one SDRAM command port.
// One transaction in flight at a time: IDLE -> ISSUE -> (WAIT_RD) -> IDLE.
module sdram_arbiter #(
    parameter int N  = 3,
    parameter int AW = 24,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             reset,
    sdram_arbiter_if.slave   bus
);
    localparam int LW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] g_q, g_d;
    logic [LW-1:0] last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic [LW-1:0] cand;
    logic [LW-1:0] win;
    logic          found;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign addr_a[i]  = bus.addr[i*AW +: AW];
        assign wdata_a[i] = bus.wdata[i*DW +: DW];
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        cand  = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = LW'((int'(last_q) + i) % N);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and output computation; the ack cycle blocks re-arbitration.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (found && (ack_q == '0)) begin
                    g_d     = win;
                    last_d  = win;
                    we_d    = bus.we[win];
                    addr_d  = addr_a[win];
                    wdata_d = wdata_a[win];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ack) begin
                    if (we_q) begin
                        ack_d[g_q] = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (bus.mem_rvalid) begin
                    rdata_d    = bus.mem_rdata;
                    ack_d[g_q] = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched command registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= LW'(N - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = (state_q == ISSUE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: cycle table plus multi-cycle corner sequences.
// Inputs change 1ns after each rising edge; outputs are checked at the same point.
module tb_sdram_arbiter;
    localparam int N  = 3;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    sdram_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    sdram_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic        mack;
        logic        rv;
        logic [15:0] mrd;
        logic [2:0]  e_ack;
        logic        e_mreq;
        logic        e_mwe;
        logic [23:0] e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t tv[13];

    function automatic vec_t mk(
        logic [2:0] req, logic [2:0] we, logic mack, logic rv,
        logic [15:0] mrd, logic [2:0] e_ack, logic e_mreq, logic e_mwe,
        logic [23:0] e_addr, logic [15:0] e_wdata, logic [15:0] e_rdata);
        vec_t v;
        v.req = req; v.we = we; v.mack = mack; v.rv = rv; v.mrd = mrd;
        v.e_ack = e_ack; v.e_mreq = e_mreq; v.e_mwe = e_mwe;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req        = '0;
        bus.we         = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_outputs_zero(string tag);
        chk({tag, "_ack"}, 64'(bus.ack), 64'h0);
        chk({tag, "_mreq"}, 64'(bus.mem_req), 64'h0);
        chk({tag, "_fields"},
            64'({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata}), 64'h0);
    endtask

    initial begin
        int grants[$];
        bit two_acks;

        bus.addr  = {24'h000789, 24'h000456, 24'h000123};
        bus.wdata = {16'h2222, 16'h1111, 16'hBEEF};
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        chk_outputs_zero("reset");
        reset = 1'b0;

        // Write from 0, REQ-held ack cycle, read from 1 with stale inputs.
        tv[0]  = mk(3'b001, 3'b001, 0, 0, 16'h0,    3'b000, 1, 1, 24'h123, 16'hBEEF, 16'h0);
        tv[1]  = mk(3'b001, 3'b001, 1, 0, 16'h0,    3'b001, 0, 1, 24'h123, 16'hBEEF, 16'h0);
        tv[2]  = mk(3'b001, 3'b001, 0, 0, 16'h0,    3'b000, 0, 1, 24'h123, 16'hBEEF, 16'h0);
        tv[3]  = mk(3'b000, 3'b000, 0, 0, 16'h0,    3'b000, 0, 1, 24'h123, 16'hBEEF, 16'h0);
        tv[4]  = mk(3'b010, 3'b000, 0, 0, 16'h0,    3'b000, 1, 0, 24'h456, 16'h1111, 16'h0);
        tv[5]  = mk(3'b010, 3'b000, 1, 0, 16'h0,    3'b000, 0, 0, 24'h456, 16'h1111, 16'h0);
        tv[6]  = mk(3'b010, 3'b000, 1, 0, 16'h0,    3'b000, 0, 0, 24'h456, 16'h1111, 16'h0);
        tv[7]  = mk(3'b010, 3'b000, 0, 0, 16'h0,    3'b000, 0, 0, 24'h456, 16'h1111, 16'h0);
        tv[8]  = mk(3'b010, 3'b000, 0, 0, 16'h0,    3'b000, 0, 0, 24'h456, 16'h1111, 16'h0);
        tv[9]  = mk(3'b010, 3'b000, 0, 1, 16'h5A5A, 3'b010, 0, 0, 24'h456, 16'h1111, 16'h5A5A);
        tv[10] = mk(3'b000, 3'b000, 0, 0, 16'h0,    3'b000, 0, 0, 24'h456, 16'h1111, 16'h5A5A);
        tv[11] = mk(3'b000, 3'b000, 0, 1, 16'h1234, 3'b000, 0, 0, 24'h456, 16'h1111, 16'h5A5A);
        tv[12] = mk(3'b000, 3'b000, 1, 0, 16'h0,    3'b000, 0, 0, 24'h456, 16'h1111, 16'h5A5A);

        for (int i = 0; i < 13; i++) begin
            bus.req        = tv[i].req;
            bus.we         = tv[i].we;
            bus.mem_ack    = tv[i].mack;
            bus.mem_rvalid = tv[i].rv;
            bus.mem_rdata  = tv[i].mrd;
            step();
            chk($sformatf("row%0d_ack", i), 64'(bus.ack), 64'(tv[i].e_ack));
            chk($sformatf("row%0d_mreq", i), 64'(bus.mem_req), 64'(tv[i].e_mreq));
            chk($sformatf("row%0d_mwe", i), 64'(bus.mem_we), 64'(tv[i].e_mwe));
            chk($sformatf("row%0d_maddr", i), 64'(bus.mem_addr), 64'(tv[i].e_addr));
            chk($sformatf("row%0d_mwdata", i), 64'(bus.mem_wdata), 64'(tv[i].e_wdata));
            chk($sformatf("row%0d_rdata", i), 64'(bus.rdata), 64'(tv[i].e_rdata));
        end

        // Contention: all three write, controller accepts immediately.
        do_reset();
        bus.req  = 3'b111;
        bus.we   = 3'b111;
        two_acks = 1'b0;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            step();
            bus.mem_ack = bus.mem_req;
            if ($countones(bus.ack) > 1) two_acks = 1'b1;
            for (int b = 0; b < N; b++)
                if (bus.ack[b]) grants.push_back(b);
        end
        chk("cont_count", 64'(grants.size()), 64'd4);
        chk("cont_onehot", 64'(two_acks), 64'd0);
        if (grants.size() == 4) begin
            chk("cont_g0", 64'(grants[0]), 64'd0);
            chk("cont_g1", 64'(grants[1]), 64'd1);
            chk("cont_g2", 64'(grants[2]), 64'd2);
            chk("cont_g3", 64'(grants[3]), 64'd0);
        end

        // Backpressure: write from 2 held in ISSUE for 10 cycles.
        do_reset();
        bus.req = 3'b100;
        bus.we  = 3'b100;
        step();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_hold%0d", c),
                64'({bus.ack, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                64'({3'b000, 1'b1, 1'b1, 24'h000789, 16'h2222}));
            step();
        end
        chk("bp_hold10_mreq", 64'(bus.mem_req), 64'd1);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        bus.req     = '0;
        chk("bp_ack", 64'(bus.ack), 64'b100);
        chk("bp_mreq_low", 64'(bus.mem_req), 64'd0);

        // Reset two cycles into WAIT_RD; late rvalid must be ignored.
        do_reset();
        bus.req = 3'b010;
        bus.we  = 3'b000;
        step();
        chk("rst_rd_issue", 64'(bus.mem_addr), 64'h456);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk_outputs_zero("async_rst");
        step();
        reset          = 1'b0;
        bus.req        = '0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h7777;
        step();
        bus.mem_rvalid = 1'b0;
        chk_outputs_zero("rst_late_rv");
        step();
        chk("rst_no_ack", 64'(bus.ack), 64'd0);
        bus.req = 3'b001;
        bus.we  = 3'b001;
        step();
        chk("rst_idle_mreq", 64'(bus.mem_req), 64'd1);
        chk("rst_idle_addr", 64'(bus.mem_addr), 64'h123);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter N, default 3: number of requesters (2..4).
REQ-002 SHALL have parameter AW, default 24: word address width.
REQ-003 SHALL have parameter DW, default 16: data width.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port req  input  N: per-requester transaction request, level.
REQ-007 SHALL have port we  input  N: per-requester write (1) / read (0).
REQ-008 SHALL have port addr  input  N*AW: per-requester address, slice i = requester i.
REQ-009 SHALL have port wdata  input  N*DW: per-requester write data.
REQ-010 SHALL have port ack  output  N: one-cycle completion pulse per requester.
REQ-011 SHALL have port rdata  output  DW: read data, valid while the ack bit of a read is high.
REQ-012 SHALL have port mem_req  output  1: command request to the SDRAM controller.
REQ-013 SHALL have port mem_we, mem_addr[AW], mem_wdata[DW]  output: command fields.
REQ-014 SHALL have port mem_ack  input  1: controller accepted the command this cycle.
REQ-015 SHALL have port mem_rvalid  input  1 and mem_rdata  input  DW: read return.

Function
REQ-016 SHALL hold exactly one transaction outstanding at a time; states IDLE, ISSUE, WAIT_RD.
REQ-017 In IDLE with any req bit high, SHALL pick winner g by round-robin starting at (last+1) mod N, latch g and its we/addr/wdata, set last=g, and enter ISSUE on the next edge.
REQ-018 In IDLE with req all zero, SHALL stay in IDLE; last unchanged.
REQ-019 In ISSUE, SHALL drive mem_req=1 with the latched fields, held stable until mem_ack samples high.
REQ-020 On mem_ack in ISSUE: write -> ack[g]=1 on the next cycle, return to IDLE; read -> enter WAIT_RD.
REQ-021 In WAIT_RD, on mem_rvalid=1 SHALL register mem_rdata into rdata, pulse ack[g] for the next cycle, and return to IDLE.
REQ-022 SHALL ignore mem_rvalid outside WAIT_RD and mem_ack outside ISSUE.
REQ-023 Minimum write latency: req high at edge k -> mem_req high from k+1 -> with mem_ack at k+1, ack[g] high in cycle k+2.
REQ-024 SHALL not sample a new request in the cycle ack is high (IDLE re-entry): arbitration resumes on the following edge, so back-to-back grants are at least 3 cycles apart.
REQ-025 Requesters hold req/we/addr/wdata until their ack; a req dropped before selection is never issued; a req dropped after selection does not abort the latched transaction.
REQ-026 Simultaneous requests: with last=N-1 and all req high, SHALL grant 0, then 1, then 2 (N=3), each in turn; no requester waits more than N-1 grants.
REQ-027 At most one ack bit high in any cycle; rdata holds its last value otherwise.

Reset
REQ-028 On reset high, SHALL immediately force state=IDLE, ack=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, last=N-1, independent of clk.
REQ-029 Reset mid-transaction SHALL abandon it with no ack; any later mem_rvalid is ignored per REQ-022.
REQ-030 After reset deasserts, first arbitration occurs on the first rising edge with reset low.

Verification
REQ-031 Single write: req=001, we=001, addr0=0x000123, wdata0=0xBEEF, mem_ack 1 cycle after mem_req -> mem_addr=0x000123, mem_wdata=0xBEEF, mem_we=1, ack=001 for exactly one cycle.
REQ-032 Single read: req=010, we=0, mem_rvalid with mem_rdata=0x5A5A 4 cycles after mem_ack -> ack=010 one cycle, rdata=0x5A5A in that cycle.
REQ-033 Contention: req=111 held, immediate mem_ack, after reset -> grant order 0,1,2,0; never two ack bits at once.
REQ-034 Backpressure: mem_ack held low 10 cycles -> mem_req and all mem_* fields stable for all 10 cycles, no ack.
REQ-035 Reset in WAIT_RD: assert reset 2 cycles after mem_ack of a read, deassert, then drive mem_rvalid -> no ack pulse, all outputs 0, state IDLE.
REQ-036 Stale input: mem_rvalid pulsed in IDLE with req=000 -> no ack, rdata unchanged.
